// File: rtl/spi_upcounter_ctrl.sv
// Decimal up-counter (0..CNT_MAX) sent as a cs_n-framed SPI write on every change; SPI_UPCNT_CHECKSUM_EN adds B2 = B0 ^ B1.
// Latency: count updates 1 clk after tick/clear; a frame starts 1 clk after pending is seen in IDLE.
// Backpressure: each byte waits for spi_tx_ready, then spi_done; one value is kept pending, and a newer one overwrites it and sets overrun.
module spi_upcounter_ctrl #(
  parameter int unsigned TICK_CYCLES = 10_000_000,
  parameter int unsigned CNT_MAX     = 9999,
  parameter int unsigned CS_SETUP    = 4,
  parameter int unsigned CS_HOLD     = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run_en,
  input  logic        clear,
  output logic [13:0] count,
  output logic        cs_n,
  output logic        spi_start,
  output logic [7:0]  spi_tx_data,
  input  logic        spi_tx_ready,
  input  logic        spi_done,
  output logic        busy,
  output logic        overrun
);

  localparam int unsigned TW   = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int unsigned WMAX = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
  localparam int unsigned WW   = (WMAX > 1) ? $clog2(WMAX) : 1;

`ifdef SPI_UPCNT_CHECKSUM_EN
  typedef enum logic [3:0] {IDLE, SETUP, SEND0, WAIT0, SEND1, WAIT1, SEND2, WAIT2, HOLD, GAP} state_t;
`else
  typedef enum logic [2:0] {IDLE, SETUP, SEND0, WAIT0, SEND1, WAIT1, HOLD, GAP} state_t;
`endif

  state_t        state_q;
  logic [TW-1:0] tick_q, tick_d;
  logic [13:0]   count_q, count_d;
  logic          pending_q, pending_d;
  logic          overrun_q, overrun_d;
  logic [13:0]   snap_q;
  logic [WW-1:0] wait_q;
  logic [7:0]    tx_q;
  logic          cs_n_q;
  logic          busy_q;
  logic          tick;
  logic          set_evt;
  logic          pend_take;
  logic [7:0]    b0, b1;

  assign tick      = run_en && (tick_q == TW'(TICK_CYCLES - 1));
  assign set_evt   = tick || clear;
  assign pend_take = (state_q == IDLE) && pending_q;
  assign b0        = {2'b00, snap_q[13:8]};
  assign b1        = snap_q[7:0];

  always_comb begin
    tick_d  = tick_q;
    count_d = count_q;
    if (clear) begin
      tick_d  = '0;
      count_d = '0;
    end else if (run_en) begin
      if (tick) begin
        tick_d  = '0;
        count_d = (count_q == 14'(CNT_MAX)) ? 14'd0 : count_q + 14'd1;
      end else begin
        tick_d = tick_q + TW'(1);
      end
    end
  end

  // A value taken by the FSM this cycle frees the slot, so a same-cycle update is not an overrun.
  always_comb begin
    pending_d = set_evt || (pending_q && !pend_take);
    overrun_d = overrun_q || (set_evt && pending_q && !pend_take);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tick_q    <= '0;
      count_q   <= '0;
      pending_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      tick_q    <= tick_d;
      count_q   <= count_d;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      wait_q  <= '0;
      snap_q  <= '0;
      tx_q    <= '0;
      cs_n_q  <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pending_q) begin
            state_q <= SETUP;
            snap_q  <= count_q;
            cs_n_q  <= 1'b0;
            busy_q  <= 1'b1;
            wait_q  <= '0;
          end
        end
        SETUP: begin
          if (wait_q == WW'(CS_SETUP - 1)) begin
            state_q <= SEND0;
            tx_q    <= b0;
          end else begin
            wait_q <= wait_q + WW'(1);
          end
        end
        SEND0: if (spi_tx_ready) state_q <= WAIT0;
        WAIT0: begin
          if (spi_done) begin
            state_q <= SEND1;
            tx_q    <= b1;
          end
        end
        SEND1: if (spi_tx_ready) state_q <= WAIT1;
        WAIT1: begin
          if (spi_done) begin
`ifdef SPI_UPCNT_CHECKSUM_EN
            state_q <= SEND2;
            tx_q    <= b0 ^ b1;
`else
            state_q <= HOLD;
            wait_q  <= '0;
`endif
          end
        end
`ifdef SPI_UPCNT_CHECKSUM_EN
        SEND2: if (spi_tx_ready) state_q <= WAIT2;
        WAIT2: begin
          if (spi_done) begin
            state_q <= HOLD;
            wait_q  <= '0;
          end
        end
`endif
        HOLD: begin
          if (wait_q == WW'(CS_HOLD - 1)) begin
            state_q <= GAP;
            cs_n_q  <= 1'b1;
          end else begin
            wait_q <= wait_q + WW'(1);
          end
        end
        GAP: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          cs_n_q  <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Start is gated by ready in the same cycle, so the FSM leaves SENDx on that edge and it cannot repeat.
`ifdef SPI_UPCNT_CHECKSUM_EN
  assign spi_start = spi_tx_ready &&
                     ((state_q == SEND0) || (state_q == SEND1) || (state_q == SEND2));
`else
  assign spi_start = spi_tx_ready && ((state_q == SEND0) || (state_q == SEND1));
`endif

  assign count       = count_q;
  assign cs_n        = cs_n_q;
  assign spi_tx_data = tx_q;
  assign busy        = busy_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_spi_upcounter_ctrl.sv
// Bench for spi_upcounter_ctrl: SPI master model plus frame scoreboard keyed on cs_n windows.
module tb_spi_upcounter_ctrl;

  // Short tick period keeps the run up to 9998 within a few tens of thousands of cycles.
  localparam int TICKS    = 2;
  localparam int CS_SETUP = 4;
  localparam int CS_HOLD  = 4;
  localparam int DONE_DLY = 20;
`ifdef SPI_UPCNT_CHECKSUM_EN
  localparam int NB = 3;
`else
  localparam int NB = 2;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        run_en = 1'b0;
  logic        clear = 1'b0;
  logic        spi_tx_ready = 1'b1;
  logic        spi_done = 1'b0;
  logic [13:0] count;
  logic        cs_n;
  logic        spi_start;
  logic [7:0]  spi_tx_data;
  logic        busy;
  logic        overrun;

  int          n_chk = 0;
  int          n_bad = 0;
  logic [13:0] exp_q[$];
  logic [7:0]  fb[$];
  bit          sb_en = 1'b1;
  bit          chk_timing = 1'b1;
  bit          done_hold = 1'b0;
  bit          in_frame = 1'b0;
  bit          started = 1'b0;
  bit          prev_start = 1'b0;
  int          n_starts = 0;
  int          n_frames = 0;
  int          tmr = 0;
  int          setup_cnt = 0;
  int          hold_cnt = 0;
  int          high_cnt = 2;

  always #5 clk = ~clk;

  spi_upcounter_ctrl #(
    .TICK_CYCLES(TICKS),
    .CNT_MAX    (9999),
    .CS_SETUP   (CS_SETUP),
    .CS_HOLD    (CS_HOLD)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .run_en      (run_en),
    .clear       (clear),
    .count       (count),
    .cs_n        (cs_n),
    .spi_start   (spi_start),
    .spi_tx_data (spi_tx_data),
    .spi_tx_ready(spi_tx_ready),
    .spi_done    (spi_done),
    .busy        (busy),
    .overrun     (overrun)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h", tag, got, exp);
    end
  endtask

  task automatic frame_end();
    logic [13:0] v;
    logic [7:0]  e0, e1;
    n_frames++;
    if (chk_timing) chk("cs_hold", hold_cnt, CS_HOLD);
    if (sb_en) begin
      chk("sb_has_exp", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        v  = exp_q.pop_front();
        e0 = {2'b00, v[13:8]};
        e1 = v[7:0];
        chk("nbytes", fb.size(), NB);
        if (fb.size() >= 2) begin
          chk("byte0", fb[0], e0);
          chk("byte1", fb[1], e1);
        end
`ifdef SPI_UPCNT_CHECKSUM_EN
        if (fb.size() >= 3) chk("byte2", fb[2], e0 ^ e1);
`endif
      end
    end
  endtask

  // SPI master model and frame monitor, both mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        in_frame   = 1'b0;
        tmr        = 0;
        spi_done   = 1'b0;
        prev_start = 1'b0;
        high_cnt   = 2;
      end else begin
        if (spi_start) begin
          chk("start_gap", prev_start, 0);
          chk("start_in_cs", cs_n, 0);
        end
        if (!cs_n) begin
          if (!in_frame) begin
            chk("cs_gap_min", high_cnt >= 2, 1);
            in_frame  = 1'b1;
            started   = 1'b0;
            setup_cnt = 0;
            hold_cnt  = 0;
            fb.delete();
          end
          if (spi_start) begin
            if (!started && chk_timing) chk("cs_setup", setup_cnt, CS_SETUP);
            started = 1'b1;
            fb.push_back(spi_tx_data);
            n_starts++;
          end else if (!started) begin
            setup_cnt++;
          end
          hold_cnt++;
        end else begin
          if (in_frame) begin
            in_frame = 1'b0;
            frame_end();
            high_cnt = 0;
          end
          high_cnt++;
        end
        prev_start = spi_start;
        spi_done = 1'b0;
        if (spi_start) tmr = DONE_DLY;
        else if (tmr > 1) tmr--;
        else if (tmr == 1 && !done_hold) begin
          tmr      = 0;
          spi_done = 1'b1;
          hold_cnt = 0;
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic run_cycles(input int n);
    run_en = 1'b1;
    cyc(n);
    run_en = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int quiet = 0;
    int n = 0;
    while (quiet < 3 && n < 2000) begin
      cyc(1);
      n++;
      quiet = busy ? 0 : quiet + 1;
    end
    chk(tag, quiet, 3);
  endtask

  task automatic wait_starts(input int target, input string tag);
    int n = 0;
    while (n_starts < target && n < 500) begin
      cyc(1);
      n++;
    end
    chk(tag, n_starts, target);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached total=%0d bad=%0d", n_chk, n_bad);
    $fatal(1);
  end

  initial begin
    int s0;
    int nf;
    cyc(3);
    chk("rst_count", count, 0);
    chk("rst_cs_n", cs_n, 1);
    chk("rst_start", spi_start, 0);
    chk("rst_txdata", spi_tx_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overrun", overrun, 0);
    reset = 1'b1;
    cyc(2);
    chk("idle_after_rst", busy, 0);

    exp_q.push_back(14'd1);
    run_cycles(2);
    chk("tick1_count", count, 1);
    cyc(2);
    chk("frame_busy", busy, 1);
    chk("frame_cs_n", cs_n, 0);
    wait_idle("idle1");
    chk("frozen_count", count, 1);

    for (int v = 2; v <= 5; v++) begin
      exp_q.push_back(14'(v));
      run_cycles(2);
      chk("tick_count", count, v);
      wait_idle("idle_n");
    end

    exp_q.push_back(14'd0);
    run_en = 1'b1;
    cyc(1);
    clear = 1'b1;
    cyc(1);
    clear  = 1'b0;
    run_en = 1'b0;
    chk("clear_count", count, 0);
    wait_idle("idle_clr");
    chk("clear_overrun", overrun, 0);
    chk("clear_frames", n_frames, 6);

    done_hold = 1'b1;
    s0 = n_starts;
    exp_q.push_back(14'd1);
    run_cycles(2);
    cyc(15);
    chk("ovr_first_start", n_starts, s0 + 1);
    for (int k = 0; k < 3; k++) run_cycles(2);
    chk("ovr_count", count, 4);
    chk("ovr_flag", overrun, 1);
    chk("ovr_busy", busy, 1);
    cyc(25);
    chk("ovr_no_start", n_starts, s0 + 1);
    exp_q.push_back(14'd4);
    done_hold = 1'b0;
    wait_idle("idle_ovr");
    chk("ovr_frames", n_frames, 8);
    chk("ovr_sticky", overrun, 1);
    reset = 1'b0;
    cyc(2);
    chk("rst2_overrun", overrun, 0);
    chk("rst2_count", count, 0);
    reset = 1'b1;
    cyc(2);

    chk_timing   = 1'b0;
    spi_tx_ready = 1'b0;
    s0 = n_starts;
    exp_q.push_back(14'd1);
    run_cycles(2);
    cyc(12);
    chk("rdy_no_start", n_starts, s0);
    chk("rdy_start_low", spi_start, 0);
    chk("rdy_cs_n", cs_n, 0);
    spi_tx_ready = 1'b1;
    #1;
    chk("rdy_start_hi", spi_start, 1);
    chk("rdy_b0", spi_tx_data, 8'h00);
    cyc(1);
    chk("rdy_start_1clk", spi_start, 0);
    wait_starts(s0 + 2, "rdy_second_start");
    cyc(3);
    chk("w1_txdata", spi_tx_data, 8'h01);
    chk("w1_busy", busy, 1);
    reset = 1'b0;
    #1;
    chk("arst_cs_n", cs_n, 1);
    chk("arst_busy", busy, 0);
    chk("arst_start", spi_start, 0);
    exp_q.delete();
    nf = n_frames;
    cyc(3);
    reset = 1'b1;
    cyc(100);
    chk("no_resend", n_frames, nf);
    chk("post_rst_cs_n", cs_n, 1);
    chk_timing = 1'b1;

    sb_en = 1'b0;
    run_cycles(2 * 9998);
    chk("pre_wrap_count", count, 9998);
    wait_idle("idle_churn");
    sb_en = 1'b1;
    exp_q.push_back(14'd9999);
    run_cycles(2);
    chk("count_max", count, 9999);
    wait_idle("idle_max");
    exp_q.push_back(14'd0);
    run_cycles(2);
    chk("count_wrap", count, 0);
    wait_idle("idle_wrap");

`ifdef SPI_UPCNT_CHECKSUM_EN
    sb_en = 1'b0;
    run_cycles(2 * 4659);
    chk("pre_cs_count", count, 4659);
    wait_idle("idle_cs_churn");
    sb_en = 1'b1;
    exp_q.push_back(14'h1234);
    run_cycles(2);
    wait_idle("idle_cs");
`endif

    chk("sb_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/spi_upcounter_ctrl.md
Name: spi_upcounter_ctrl

Overview:
Sequencer that owns the 8-bit SPI master in the up-counter design. It keeps a free-running decimal up-counter (0..9999) that advances on a periodic tick. On every counter change it frames the value as a 2-byte SPI write under an active-low chip select. It drives the master's start/tx_data interface and waits for its done pulse before moving on.

Parameters:
TICK_CYCLES, 10_000_000, clk cycles per count increment (100 ms at 100 MHz); legal range >= 2
CNT_MAX, 9999, last counter value before wrap to 0
CS_SETUP, 4, clk cycles cs_n is low before the first spi_start
CS_HOLD, 4, clk cycles after the last spi_done before cs_n returns high

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset (0 = in reset)
run_en  input  1  1 = tick counter runs and count advances; 0 = tick counter and count frozen
clear  input  1  single-cycle pulse: count <= 0 and request a frame
count  output  14  current counter value
cs_n  output  1  SPI chip select, active low
spi_start  output  1  one-cycle start to SPI master
spi_tx_data  output  8  byte to SPI master, valid while spi_start = 1
spi_tx_ready  input  1  SPI master idle/ready
spi_done  input  1  SPI master byte-complete pulse
busy  output  1  1 whenever state != IDLE
overrun  output  1  sticky: a new value arrived while one was already pending; cleared only by reset

Behaviour:
- Reset (asserted, async): count=0, tick counter=0, cs_n=1, spi_start=0, spi_tx_data=0, busy=0, overrun=0, pending=0, state=IDLE.
- Tick: counter runs 0..TICK_CYCLES-1 while run_en=1. The cycle at TICK_CYCLES-1 is the tick; the counter then wraps to 0.
- On tick: count <= (count==CNT_MAX) ? 0 : count+1, and pending <= 1. Latency is 1 clk.
- clear has priority over a same-cycle tick: count <= 0, tick counter <= 0, pending <= 1.
- Snapshot: when the FSM leaves IDLE, snap <= count and pending <= 0. Later count changes do not alter the frame in flight.
- Pending is one-deep. A pending set while pending is already 1 sets overrun=1; the newest value is sent, since the snapshot is taken at frame start.
- Frame bytes: B0 = {2'b00, snap[13:8]}, B1 = snap[7:0]. Sent MSB byte first.
- FSM states: IDLE, SETUP, SEND0, WAIT0, SEND1, WAIT1, HOLD, GAP.
  - IDLE: cs_n=1. If pending: go to SETUP and take the snapshot.
  - SETUP: cs_n=0 for CS_SETUP cycles, then go to SEND0.
  - SEND0: spi_tx_data=B0. spi_start=1 only in a cycle with spi_tx_ready=1, then go to WAIT0. Otherwise stay with spi_start=0.
  - WAIT0: on spi_done go to SEND1. spi_start stays 0.
  - SEND1 / WAIT1: same as SEND0 / WAIT0 with B1. spi_done in WAIT1 goes to HOLD.
  - HOLD: cs_n=0 for CS_HOLD cycles, then go to GAP.
  - GAP: cs_n=1 for exactly 1 cycle, then go to IDLE. If pending, a new frame starts from IDLE on the next cycle, so cs_n is high for a minimum of 2 cycles between frames.
- spi_start is never high for 2 consecutive cycles, and never high outside SEND0/SEND1. spi_tx_data holds its value from SEND0/SEND1 until the next SEND state.
- cs_n stays low continuously from SETUP through HOLD.
- spi_done outside WAIT0/WAIT1 is ignored.
- run_en=0 mid-frame does not abort the frame. Only reset aborts.
- Reset mid-frame: cs_n goes high immediately (async). The frame is dropped and not resent after reset release.

Optional Feature:
SPI_UPCNT_CHECKSUM_EN
- Defined: the frame is 3 bytes, with B2 = B0 ^ B1. States SEND2/WAIT2 are inserted between WAIT1 and HOLD, and cs_n stays low across all 3 bytes.
- Undefined: the frame is 2 bytes exactly as above, and no SEND2/WAIT2 logic exists.

Test Plan:
- Test configuration: TICK_CYCLES=10, CS_SETUP=4, CS_HOLD=4, run_en=1, spi_tx_ready=1, spi_done driven 20 clk after each spi_start. Expect first tick -> count=1 -> cs_n low, B0=0x00 then B1=0x01, cs_n high 4 clk after the 2nd spi_done.
- count forced to 9998 via ticks -> next tick gives count=9999 (B0=0x27, B1=0x0F), following tick gives count=0 (B0=0x00, B1=0x00).
- clear and tick in the same cycle with count=5 -> count=0, one frame carrying 0x00,0x00, overrun stays 0.
- Hold spi_done off for 3 ticks during WAIT0 -> overrun=1, busy=1, no second spi_start until spi_done. Next frame carries the latest count.
- spi_tx_ready=0 for 7 clk in SEND0 -> spi_start stays 0, then rises for exactly 1 clk when ready rises. Assert reset mid-WAIT1 -> cs_n=1, busy=0, spi_start=0 immediately.
- With SPI_UPCNT_CHECKSUM_EN defined and count=0x1234 -> bytes 0x12, 0x34, 0x26 under one continuous cs_n-low window.
